// File: rtl/prm_pkg.sv
// Shared types and sizing helpers for the PRM edge-collision accumulator.
package prm_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_FLUSH,
        S_DRAIN
    } state_t;

    localparam int XW_DEF    = 4;
    localparam int YW_DEF    = 5;
    localparam int ZW_DEF    = 5;
    localparam int PARTS_DEF = 8;
    localparam int PW_DEF    = 512;
    localparam int OUTW_DEF  = 32;
    localparam int CW_DEF    = 16;

    function automatic int nwords(int parts, int pw, int outw);
        return parts * pw / outw;
    endfunction

    function automatic int idx_w(int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int NWORDS_DEF = nwords(PARTS_DEF, PW_DEF, OUTW_DEF);
    localparam int IDXW_DEF   = idx_w(NWORDS_DEF);

endpackage

// File: rtl/prm_word_mux.sv
// Picks one OUTW-bit word of the accumulator and optionally inverts it.
// Output is forced to zero when not enabled so idle cycles read as 0.
module prm_word_mux
    import prm_pkg::*;
#(
    parameter int PARTS   = PARTS_DEF,
    parameter int PW      = PW_DEF,
    parameter int OUTW    = OUTW_DEF,
    parameter bit OUT_REG = 1'b0
) (
    input  logic                            CLK,
    input  logic                            RST,
    input  logic [PARTS*PW-1:0]             acc,
    input  logic [idx_w(nwords(PARTS, PW, OUTW))-1:0] idx,
    input  logic                            inv,
    input  logic                            en,
    output logic [OUTW-1:0]                 word
);

    localparam int NW = nwords(PARTS, PW, OUTW);

    logic [OUTW-1:0] words [NW];
    logic [OUTW-1:0] sel;
    logic [OUTW-1:0] word_q;

    for (genvar i = 0; i < NW; i++) begin : g_w
        assign words[i] = acc[i*OUTW +: OUTW];
    end

    always_comb begin
        sel = '0;
        if (en) begin
            sel = words[idx] ^ {OUTW{inv}};
        end
    end

    // Registered copy adds one cycle of latency; unused unless OUT_REG.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            word_q <= '0;
        end else begin
            word_q <= sel;
        end
    end

    assign word = OUT_REG ? word_q : sel;

endmodule

// File: rtl/prm_edge_accum.sv
// Frame-based edge-collision accumulator: streams voxels to external LUTs,
// ORs returned masks, then drains the result word by word.
module prm_edge_accum
    import prm_pkg::*;
#(
    parameter int XW    = XW_DEF,
    parameter int YW    = YW_DEF,
    parameter int ZW    = ZW_DEF,
    parameter int PARTS = PARTS_DEF,
    parameter int PW    = PW_DEF,
    parameter int OUTW  = OUTW_DEF,
    parameter int CW    = CW_DEF
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [XW+YW+ZW-1:0]      in_xyz,
    input  logic                     in_last,
    input  logic                     free_mode,
    output logic [XW-1:0]            x,
    output logic [YW-1:0]            y,
    output logic [ZW-1:0]            z,
    input  logic [PARTS*PW-1:0]      edge_mask,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OUTW-1:0]          out_data,
    output logic [idx_w(nwords(PARTS, PW, OUTW))-1:0] out_idx,
    output logic [CW-1:0]            vox_cnt,
    output logic                     frame_done
);

    localparam int NW = nwords(PARTS, PW, OUTW);
    localparam int IW = idx_w(NW);

    state_t               state;
    state_t               nxt;
    logic [PARTS*PW-1:0]  acc;
    logic [IW-1:0]        idx;
    logic                 s1_valid;
    logic                 free_q;
    logic                 in_fire;
    logic                 out_fire;
    logic                 last_word;

    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
    assign last_word = (idx == IW'(NW - 1));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt = state;
        unique case (state)
            S_IDLE: begin
                if (in_fire) begin
                    nxt = in_last ? S_FLUSH : S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (in_fire && in_last) begin
                    nxt = S_FLUSH;
                end
            end
            S_FLUSH: nxt = S_DRAIN;
            S_DRAIN: begin
                if (out_fire && last_word) begin
                    nxt = S_IDLE;
                end
            end
            default: nxt = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready   = (state == S_IDLE) || (state == S_ACCUM);
        out_valid  = (state == S_DRAIN);
        frame_done = (state == S_DRAIN) && out_ready && last_word;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            x        <= '0;
            y        <= '0;
            z        <= '0;
            s1_valid <= 1'b0;
            free_q   <= 1'b0;
            vox_cnt  <= '0;
            acc      <= '0;
            idx      <= '0;
        end else begin
            s1_valid <= in_fire;
            if (in_fire) begin
                x <= in_xyz[XW+YW+ZW-1 -: XW];
                y <= in_xyz[YW+ZW-1 -: YW];
                z <= in_xyz[ZW-1:0];
            end
            // Mode and count restart on the first beat of each frame.
            if (in_fire && state == S_IDLE) begin
                free_q  <= free_mode;
                vox_cnt <= CW'(1);
            end else if (in_fire && vox_cnt != '1) begin
                vox_cnt <= vox_cnt + CW'(1);
            end
            if (frame_done) begin
                acc <= '0;
                idx <= '0;
            end else begin
                if (s1_valid) begin
                    acc <= acc | edge_mask;
                end
                if (out_fire) begin
                    idx <= idx + IW'(1);
                end
            end
        end
    end

    prm_word_mux #(
        .PARTS   (PARTS),
        .PW      (PW),
        .OUTW    (OUTW),
        .OUT_REG (1'b0)
    ) u_mux (
        .CLK  (CLK),
        .RST  (RST),
        .acc  (acc),
        .idx  (idx),
        .inv  (free_q),
        .en   (out_valid),
        .word (out_data)
    );

    assign out_idx = idx;

endmodule

// File: tb/tb_prm_edge_accum.sv
// Directed bench for prm_edge_accum with a small LUT model and
// a CW=4 twin instance for counter saturation.
module tb_prm_edge_accum;
    import prm_pkg::*;

    localparam int NW = NWORDS_DEF;
    localparam int IW = IDXW_DEF;
    localparam int AW = PARTS_DEF * PW_DEF;

    logic          CLK = 1'b0;
    logic          RST;
    logic          in_valid, in_last, free_mode, out_ready;
    logic [13:0]   in_xyz;
    logic [3:0]    x;
    logic [4:0]    y, z;
    logic [AW-1:0] edge_mask;
    logic          in_ready, out_valid, frame_done;
    logic [31:0]   out_data;
    logic [IW-1:0] out_idx;
    logic [15:0]   vox_cnt;

    logic          s_in_ready, s_out_valid, s_frame_done;
    logic [3:0]    s_x;
    logic [4:0]    s_y, s_z;
    logic [31:0]   s_out_data;
    logic [IW-1:0] s_out_idx;
    logic [3:0]    s_vox_cnt;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    prm_edge_accum dut (
        .CLK(CLK), .RST(RST),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_xyz(in_xyz), .in_last(in_last), .free_mode(free_mode),
        .x(x), .y(y), .z(z), .edge_mask(edge_mask),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_idx(out_idx),
        .vox_cnt(vox_cnt), .frame_done(frame_done)
    );

    prm_edge_accum #(.CW(4)) dut_sat (
        .CLK(CLK), .RST(RST),
        .in_valid(in_valid), .in_ready(s_in_ready),
        .in_xyz(in_xyz), .in_last(in_last), .free_mode(free_mode),
        .x(s_x), .y(s_y), .z(s_z), .edge_mask(edge_mask),
        .out_valid(s_out_valid), .out_ready(out_ready),
        .out_data(s_out_data), .out_idx(s_out_idx),
        .vox_cnt(s_vox_cnt), .frame_done(s_frame_done)
    );

    function automatic logic [AW-1:0] lut(input logic [13:0] k);
        logic [AW-1:0] m;
        m = '0;
        case (k)
            14'h0123: begin m[5] = 1'b1; m[600] = 1'b1; end
            14'h0001: begin m[0] = 1'b1; m[1] = 1'b1; end
            14'h0002: begin m[1] = 1'b1; m[2] = 1'b1; end
            14'h0003: m[4095] = 1'b1;
            default: ;
        endcase
        return m;
    endfunction

    always_comb edge_mask = lut({x, y, z});

    task automatic beat(input logic [13:0] k, input logic last,
                        input logic fm);
        in_valid  = 1'b1;
        in_xyz    = k;
        in_last   = last;
        free_mode = fm;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL in_ready k=%h: got %b want 1", k, in_ready);
        end
        @(negedge CLK);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Called at the negedge of the first DRAIN cycle.
    task automatic drain(input logic [AW-1:0] exp, input logic inv,
                         input string nm, input bit rnd);
        int n = 0;
        int cyc = 0;
        int pulses = 0;
        bit stalled = 0;
        logic [31:0] pd = '0;
        logic [IW-1:0] pi = '0;
        logic [31:0] ew;
        while (n < NW && cyc < 4000) begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            ew = exp[n*32 +: 32] ^ {32{inv}};
            checks++;
            if (out_valid !== 1'b1 || out_idx !== IW'(n) ||
                out_data !== ew) begin
                errors++;
                $display("FAIL %s word: got v=%b i=%0d d=%h want v=1 i=%0d d=%h",
                         nm, out_valid, out_idx, out_data, n, ew);
            end
            if (stalled) begin
                checks++;
                if (out_data !== pd || out_idx !== pi) begin
                    errors++;
                    $display("FAIL %s stall: got i=%0d d=%h want i=%0d d=%h",
                             nm, out_idx, out_data, pi, pd);
                end
            end
            if (frame_done === 1'b1) pulses++;
            if (out_ready) n++;
            stalled = !out_ready;
            pd = out_data;
            pi = out_idx;
            @(negedge CLK);
            cyc++;
        end
        out_ready = 1'b0;
        #1;
        checks++;
        if (n != NW) begin
            errors++;
            $display("FAIL %s transfers: got %0d want %0d", nm, n, NW);
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL %s frame_done: got %0d pulses want 1", nm, pulses);
        end
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL %s post: got ov=%b ir=%b fd=%b want 0 1 0",
                     nm, out_valid, in_ready, frame_done);
        end
    endtask

    // Last beat just accepted; checks FLUSH then first DRAIN cycle.
    task automatic to_drain(input string nm, input int cnt);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s flush: got ov=%b want 0", nm, out_valid);
        end
        @(negedge CLK);
        checks++;
        if (out_valid !== 1'b1 || vox_cnt !== 16'(cnt)) begin
            errors++;
            $display("FAIL %s drain start: got ov=%b cnt=%0d want 1 %0d",
                     nm, out_valid, vox_cnt, cnt);
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== '0 ||
            frame_done !== 1'b0 || {x, y, z} !== '0 || vox_cnt !== '0 ||
            out_idx !== '0) begin
            errors++;
            $display("FAIL reset: got ir=%b ov=%b d=%h fd=%b xyz=%h cnt=%0d i=%0d want 1 0 0 0 0 0 0",
                     in_ready, out_valid, out_data, frame_done,
                     {x, y, z}, vox_cnt, out_idx);
        end
        RST = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_single();
        logic [AW-1:0] e;
        e = '0;
        e[5] = 1'b1;
        e[600] = 1'b1;
        beat(14'h0123, 1'b1, 1'b0);
        checks++;
        if ({x, y, z} !== 14'h0123) begin
            errors++;
            $display("FAIL single xyz: got %h want 0123", {x, y, z});
        end
        to_drain("single", 1);
        drain(e, 1'b0, "single", 1'b0);
        checks++;
        if (vox_cnt !== 16'd1) begin
            errors++;
            $display("FAIL single hold cnt: got %0d want 1", vox_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] e;
        e = '0;
        e[2:0] = 3'b111;
        e[4095] = 1'b1;
        beat(14'h0001, 1'b0, 1'b0);
        beat(14'h0002, 1'b0, 1'b0);
        beat(14'h0003, 1'b1, 1'b0);
        to_drain("three", 3);
        drain(e, 1'b0, "three", 1'b0);
    endtask

    task automatic test_free_mode();
        beat(14'h0100, 1'b0, 1'b1);
        beat(14'h0200, 1'b1, 1'b0);
        to_drain("free", 2);
        drain('0, 1'b1, "free", 1'b0);
    endtask

    task automatic test_backpressure();
        logic [AW-1:0] e;
        e = '0;
        e[5] = 1'b1;
        e[600] = 1'b1;
        beat(14'h0123, 1'b1, 1'b0);
        to_drain("bp", 1);
        drain(e, 1'b0, "bp", 1'b1);
    endtask

    task automatic test_reset_mid_drain();
        logic [AW-1:0] e;
        e = '0;
        e[5] = 1'b1;
        e[600] = 1'b1;
        beat(14'h0003, 1'b1, 1'b0);
        to_drain("rst_pre", 1);
        out_ready = 1'b1;
        repeat (40) @(negedge CLK);
        checks++;
        if (out_idx !== IW'(40) || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL rst idx40: got i=%0d ov=%b want 40 1",
                     out_idx, out_valid);
        end
        RST = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || dut.acc !== '0 || out_idx !== '0 ||
            vox_cnt !== '0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst mid drain: got ov=%b i=%0d cnt=%0d ir=%b accz=%b want 0 0 0 1 1",
                     out_valid, out_idx, vox_cnt, in_ready, dut.acc == '0);
        end
        out_ready = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        beat(14'h0123, 1'b1, 1'b0);
        to_drain("rst_post", 1);
        drain(e, 1'b0, "rst_post", 1'b0);
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 20; i++) begin
            beat(14'h0100, 1'(i == 19), 1'b0);
        end
        to_drain("sat", 20);
        checks++;
        if (s_vox_cnt !== 4'd15) begin
            errors++;
            $display("FAIL sat cnt: got %0d want 15", s_vox_cnt);
        end
        drain('0, 1'b0, "sat", 1'b0);
    endtask

    initial begin
        in_valid  = 1'b0;
        in_last   = 1'b0;
        free_mode = 1'b0;
        out_ready = 1'b0;
        in_xyz    = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_free_mode();
        test_backpressure();
        test_reset_mid_drain();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/prm_edge_accum.md
# prm_edge_accum

Parametrised, streaming edge-collision accumulator for the PRM checker. Accepts a frame of occupied-voxel coordinates on a valid/ready stream and drives each one into the external partitioned edge-mask LUTs. It ORs the returned masks into a PARTS×PW-bit blocked-edge accumulator, then drains the result as OUTW-bit words over a second valid/ready stream. It replaces fixed 8×512-bit, select-driven result readout with a frame-based, handshake-driven flow of arbitrary width and partition count.

## Interface
- XW, 4, x coordinate width
- YW, 5, y coordinate width
- ZW, 5, z coordinate width
- PARTS, 8, number of LUT partitions
- PW, 512, edge bits per partition; OUTW must divide PW
- OUTW, 32, output word width
- CW, 16, voxel counter width

Ports:
- CLK  in  1  sole clock, rising edge
- RST  in  1  asynchronous, active-high reset
- in_valid  in  1  voxel beat valid
- in_ready  out  1  voxel beat accepted when in_valid&in_ready
- in_xyz  in  XW+YW+ZW  {x,y,z}, x in MSBs
- in_last  in  1  marks final voxel of frame
- free_mode  in  1  sampled on first beat of frame; 1 = output inverted (free edges)
- x  out  XW  registered coordinate to LUTs
- y  out  YW  registered coordinate to LUTs
- z  out  ZW  registered coordinate to LUTs
- edge_mask  in  PARTS*PW  concatenated combinational LUT outputs, partition 0 in LSBs
- out_valid  out  1  result word valid
- out_ready  in  1  sink accepts word
- out_data  out  OUTW  result word
- out_idx  out  log2(NWORDS)  index of current word, NWORDS = PARTS*PW/OUTW
- vox_cnt  out  CW  voxels accepted in current/last frame, saturating
- frame_done  out  1  one-cycle pulse after final word accepted

## Operation
- States: IDLE, ACCUM, FLUSH, DRAIN.
- IDLE: in_ready=1. First accepted beat latches free_mode and sets vox_cnt=1. It goes to FLUSH if in_last, else ACCUM.
- ACCUM: in_ready=1. Each accepted beat increments vox_cnt, saturating at 2^CW-1. An accepted beat with in_last goes to FLUSH.
- FLUSH: in_ready=0, lasts exactly one cycle, then DRAIN.
- DRAIN: in_ready=0, out_valid=1, out_data = acc[idx*OUTW +: OUTW], XORed with all-ones if free_mode is latched.
  - idx increments on out_valid&out_ready.
  - Acceptance of word NWORDS-1: pulse frame_done, clear acc and idx, go to IDLE.
- Pipeline stage 1: an accepted beat loads x/y/z registers and sets s1_valid.
- Pipeline stage 2: when s1_valid, acc <= acc | edge_mask.
- out_data holds stable while out_valid&!out_ready.
- Empty frame is impossible; every frame has at least one beat.

## Timing
- Reset values:
  - state=IDLE, acc=0, idx=0, s1_valid=0
  - x=y=z=0, vox_cnt=0
  - in_ready=1, out_valid=0, out_data=0, frame_done=0
- Beat accepted at cycle t: x/y/z valid at t+1; mask ORed into acc at end of t+1.
- Last beat at t: FLUSH at t+1, first out_valid at t+2.
- Back-to-back beats every cycle are sustained; zero bubbles in ACCUM.
- Drain takes at least NWORDS cycles (128 at defaults) with out_ready held high.
- The first beat of the next frame is accepted the cycle after frame_done.
- vox_cnt holds its final value through DRAIN and IDLE until the next frame's first beat.
- Asserting RST at any point, including mid-ACCUM or mid-DRAIN, returns to reset values immediately. The partial frame is discarded.

## Structure
- A shared package prm_pkg holds:
  - state enum
  - NWORDS and index-width localparams as functions of PARTS/PW/OUTW
  - coordinate-width defaults
- Sub-module prm_word_mux: selects acc word by idx and applies the free_mode inversion (registered output optional, off by default).
- LUT partitions stay outside the block; the parent instantiates PARTS LUTs on x/y/z.

## Test plan
- Single-voxel frame, free_mode=0:
  - Stimulus: xyz=0x0123 with in_last; LUT model returns a mask with bits 5 and 600 set.
  - Required: word0=0x20 and word18=0x0100_0000 (bit 600 = word18 bit 24); other words 0.
  - Required: first out_valid 2 cycles after the accept; vox_cnt=1.
- Three-voxel frame, masks overlapping:
  - Stimulus: three voxels whose masks set bits {0,1}, {1,2} and {4095}.
  - Required: word0=0x7, word127=0x8000_0000, vox_cnt=3.
- free_mode=1 with an all-zero mask:
  - Required: all 128 words = 0xFFFF_FFFF.
  - Required: free_mode toggled mid-frame has no effect.
- Backpressure:
  - Stimulus: out_ready toggled randomly.
  - Required: out_data and out_idx stable while stalled; exactly 128 transfers; one frame_done pulse.
- Reset mid-DRAIN at word 40:
  - Required: out_valid=0 and acc=0 next cycle.
  - Required: the next single-voxel frame outputs only its own mask.
- Saturation at CW=4:
  - Stimulus: 20 beats in one frame.
  - Required: vox_cnt=15.
